// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the boot loader.
// master: the loader side; slave: the stream source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  // Handshake: a byte moves on a rising clk edge where in_valid && in_ready are
  // both high; the source holds in_data stable while in_valid is high and unaccepted.
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: 16-bit word count header, then big-endian
// 32-bit words written to consecutive addresses; holds the core in reset until done.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  imem_loader_if.master     bus,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] HDR_HI = 3'd0;
  localparam logic [2:0] HDR_LO = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [16:0] word_addr;
  logic [1:0]  byte_idx;
  logic [31:0] word;
  logic        accept;
  logic        in_range;

  assign accept   = bus.in_valid && bus.in_ready;
  // word_addr is wide enough to never wrap for any 16-bit count.
  assign in_range = word_addr < DEPTH_L;

  assign bus.in_ready  = rst && (state == HDR_HI || state == HDR_LO || state == DATA);
  assign bus.mem_we    = (state == WRITE) && in_range;
  assign bus.mem_addr  = word_addr[ADDR_W-1:0];
  assign bus.mem_wdata = word;
  assign cpu_rst_n     = (state == DONE);
  assign busy          = (state != DONE);
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= HDR_HI;
      cnt          <= 16'd0;
      word_addr    <= 17'd0;
      byte_idx     <= 2'd0;
      word         <= 32'd0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        HDR_HI: begin
          if (accept) begin
            cnt[15:8] <= bus.in_data;
            state     <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (accept) begin
            cnt[7:0]  <= bus.in_data;
            word_addr <= 17'd0;
            byte_idx  <= 2'd0;
            state     <= ({cnt[15:8], bus.in_data} == 16'd0) ? DONE : DATA;
          end
        end
        DATA: begin
          if (accept) begin
            word     <= {word[23:0], bus.in_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) state <= WRITE;
          end
        end
        WRITE: begin
          if (in_range) words_loaded <= words_loaded + (ADDR_W+1)'(1);
          else          err          <= 1'b1;
          word_addr <= word_addr + 17'd1;
          cnt       <= cnt - 16'd1;
          state     <= (cnt == 16'd1) ? DONE : DATA;
        end
        DONE: begin
          if (load_req) begin
            state        <= HDR_HI;
            err          <= 1'b0;
            words_loaded <= '0;
            word_addr    <= 17'd0;
            cnt          <= 16'd0;
          end
        end
        default: state <= HDR_HI;
      endcase
    end
  end

endmodule
